latch_dump_serializer: RTL and testbench

Sits between the pipeline debug outputs and the debug unit's UART TX FIFO. On a start request it takes a snapshot of the 341-bit concatenated pipeline-latch vector (IF/ID, ID/EX, EX/M, M/WB). It then streams the snapshot as bytes into the TX FIFO write port, one byte per cycle, and stalls while the FIFO is full. The debug unit's command FSM uses it to answer a "dump latches" request; it reports completion with a one-cycle pulse.

---
 rtl/debug_pkg.sv | 22 ++
 rtl/latch_dump_serializer.sv | 128 ++++++++++++
 tb/tb_latch_dump_serializer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared debug-unit definitions.
// Holds the pipeline-latch vector width, the UART word width, the latch-dump
// FSM state encoding and the debug command code that triggers a latch dump.
package debug_pkg;

    // Width of the concatenated pipeline-latch vector {IF_ID, ID_EX, EX_M, M_WB}
    localparam int unsigned NB_R_INT = 341;

    // UART data word width
    localparam int unsigned NB_BYTE = 8;

    // Command byte the debug-unit decoder maps to "dump latches"
    localparam logic [NB_BYTE-1:0] CMD_DUMP_LATCHES = 8'h4C;

    // Latch-dump serializer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_e;

endpackage : debug_pkg

// File: rtl/latch_dump_serializer.sv
// Latch dump serializer.
// Snapshots the pipeline-latch vector on a start request, then streams it
// LSB byte first into the UART TX FIFO write port, one byte per cycle,
// holding while the FIFO reports full. Completion is a one-cycle pulse.
//
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-low reset
//   i_start    dump request pulse (honoured only in IDLE)
//   i_abort    cancel the dump in progress
//   i_data     snapshot source {IF_ID, ID_EX, EX_M, M_WB}
//   i_tx_full  TX FIFO almost-full flag
//   o_tx_data  byte to TX FIFO
//   o_tx_wr    TX FIFO write strobe
//   o_busy     high from capture until completion or abort
//   o_done     one-cycle pulse after the last byte
module latch_dump_serializer
    import debug_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_R_INT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_tx_full,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_wr,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned NB_BYTES = (NB_DATA + NB_BYTE - 1) / NB_BYTE;
    localparam int unsigned NB_CNT   = $clog2(NB_BYTES);
    localparam int unsigned NB_SHIFT = NB_BYTES * NB_BYTE;

    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(NB_BYTES - 1);
    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

    dump_state_e          state_q,   state_d;
    logic [NB_SHIFT-1:0]  shift_q,   shift_d;
    logic [NB_CNT-1:0]    cnt_q,     cnt_d;
    logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
    logic                 tx_wr_q,   tx_wr_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (i_start) begin
                    // Zero-extension leaves the pad bits of the last byte at 0
                    shift_d = NB_SHIFT'(i_data);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (i_abort) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!i_tx_full) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = shift_q[NB_BYTE-1:0];
                    shift_d   = shift_q >> NB_BYTE;
                    // Counter parks on the last index instead of wrapping
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_tx_data = tx_data_q;
    assign o_tx_wr   = tx_wr_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule : latch_dump_serializer

// File: tb/tb_latch_dump_serializer.sv
// Testbench for latch_dump_serializer.
// Expected byte streams come from slicing the zero-extended snapshot into
// 8-bit chunks; written bytes and done pulses are collected by a monitor.
module tb_latch_dump_serializer;

    localparam int NB_DATA  = 341;
    localparam int NB_BYTES = 43;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_start;
    logic               i_abort;
    logic [NB_DATA-1:0] i_data;
    logic               i_tx_full;
    logic [7:0]         o_tx_data;
    logic               o_tx_wr;
    logic               o_busy;
    logic               o_done;

    int chk  = 0;
    int pass = 0;
    int cyc  = 0;

    logic [7:0] wr_q[$];
    logic [7:0] exp_q[$];
    int         done_cnt;
    int         done_cyc;

    // Snapshots taken by drive_dump
    logic       pa_wr, pa_busy, pa_done, busy_start, busy_end;
    logic [7:0] pa_data;

    latch_dump_serializer dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_start   (i_start),
        .i_abort   (i_abort),
        .i_data    (i_data),
        .i_tx_full (i_tx_full),
        .o_tx_data (o_tx_data),
        .o_tx_wr   (o_tx_wr),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: collect written bytes and done pulses
    always @(negedge clk) begin
        if (o_tx_wr) wr_q.push_back(o_tx_data);
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference model: byte k is bits [8k+7:8k] of the zero-extended snapshot
    function automatic void build_expected(input logic [NB_DATA-1:0] d);
        logic [NB_BYTES*8-1:0] v;
        v = {3'b000, d};
        exp_q.delete();
        for (int k = 0; k < NB_BYTES; k++) exp_q.push_back(v[k*8 +: 8]);
    endfunction

    function automatic int first_diff(input int n);
        for (int k = 0; k < n; k++) begin
            if (k >= wr_q.size()) return k;
            if (wr_q[k] !== exp_q[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NB_DATA-1:0] rand_data();
        logic [NB_DATA-1:0] d;
        d = '0;
        for (int i = 0; i < 11; i++) d = {d[NB_DATA-33:0], 32'($urandom())};
        return d;
    endfunction

    // act: 0 none, 1 re-start with alt data, 2 abort, 3 reset; fired once
    // the monitor holds act_byte bytes. Stall window in cycles after i_start.
    task automatic drive_dump(input logic [NB_DATA-1:0] data, input int st_lo,
                              input int st_hi, input bit rnd, input int act_byte,
                              input int act, input logic [NB_DATA-1:0] alt,
                              output int lat);
        int t0;
        int t_act;
        bit acted;
        @(posedge clk); #1;
        wr_q.delete();
        done_cnt = 0;
        lat      = -1;
        acted    = 1'b0;
        t_act    = -100;
        i_data   = data;
        i_start  = 1'b1;
        i_tx_full = 1'b0;
        t0       = cyc;
        for (int it = 0; it < 250; it++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            i_abort = 1'b0;
            rst_n   = 1'b1;
            if (it == 0) busy_start = o_busy;
            if (acted && cyc == t_act + 1) begin
                pa_wr   = o_tx_wr;
                pa_busy = o_busy;
                pa_done = o_done;
                pa_data = o_tx_data;
            end
            if (done_cnt > 0 && lat < 0) lat = done_cyc - t0;
            if (lat >= 0 && cyc >= done_cyc + 4) break;
            if (acted && act >= 2 && cyc >= t_act + 20) break;
            i_tx_full = ((cyc - t0) >= st_lo && (cyc - t0) <= st_hi) ||
                        (rnd && $urandom_range(0, 3) == 0);
            if (act != 0 && !acted && wr_q.size() == act_byte) begin
                acted = 1'b1;
                t_act = cyc;
                i_tx_full = 1'b0;
                case (act)
                    1: begin i_start = 1'b1; i_data = alt; end
                    2: i_abort = 1'b1;
                    default: rst_n = 1'b0;
                endcase
            end
        end
        busy_end  = o_busy;
        i_tx_full = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_start = 1'b1;
        i_data = '1;
        repeat (2) @(posedge clk);
        #1;
        chk++; if (o_tx_wr !== 1'b0) $display("FAIL reset_wr: got %b exp 0", o_tx_wr); else pass++;
        chk++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", o_busy); else pass++;
        chk++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b exp 0", o_done); else pass++;
        chk++; if (o_tx_data !== 8'h00) $display("FAIL reset_data: got %h exp 00", o_tx_data); else pass++;
        rst_n = 1'b1;
        i_start = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        logic [NB_DATA-1:0] d;
        int lat, fd;
        d = 341'h1_23456789_ABCDEF01;
        build_expected(d);
        drive_dump(d, 1, 0, 1'b0, 0, 0, '0, lat);
        fd = first_diff(NB_BYTES);
        chk++; if (wr_q.size() != NB_BYTES) $display("FAIL basic_count: got %0d exp %0d", wr_q.size(), NB_BYTES); else pass++;
        chk++; if (fd != -1) $display("FAIL basic_bytes: first bad byte index %0d exp none", fd); else pass++;
        chk++; if (lat != 45) $display("FAIL basic_latency: got %0d exp 45", lat); else pass++;
        chk++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d exp 1", done_cnt); else pass++;
        chk++; if (busy_start !== 1'b1) $display("FAIL basic_busy_start: got %b exp 1", busy_start); else pass++;
        chk++; if (busy_end !== 1'b0) $display("FAIL basic_busy_end: got %b exp 0", busy_end); else pass++;
    endtask

    task automatic test_all_ones();
        logic [NB_DATA-1:0] d;
        logic [7:0] last;
        int lat, fd;
        d = '1;
        build_expected(d);
        drive_dump(d, 1, 0, 1'b0, 0, 0, '0, lat);
        fd = first_diff(NB_BYTES);
        last = (wr_q.size() == NB_BYTES) ? wr_q[NB_BYTES-1] : 8'hxx;
        chk++; if (fd != -1) $display("FAIL ones_bytes: first bad byte index %0d exp none", fd); else pass++;
        chk++; if (last !== 8'h1F) $display("FAIL ones_pad: got %h exp 1f", last); else pass++;
        chk++; if (lat != 45) $display("FAIL ones_latency: got %0d exp 45", lat); else pass++;
    endtask

    task automatic test_stall();
        logic [NB_DATA-1:0] d;
        int lat, fd;
        d = 341'h1_23456789_ABCDEF01;
        build_expected(d);
        drive_dump(d, 5, 14, 1'b0, 0, 0, '0, lat);
        fd = first_diff(NB_BYTES);
        chk++; if (wr_q.size() != NB_BYTES) $display("FAIL stall_count: got %0d exp %0d", wr_q.size(), NB_BYTES); else pass++;
        chk++; if (fd != -1) $display("FAIL stall_bytes: first bad byte index %0d exp none", fd); else pass++;
        chk++; if (lat != 55) $display("FAIL stall_latency: got %0d exp 55", lat); else pass++;
        chk++; if (done_cnt != 1) $display("FAIL stall_done_count: got %0d exp 1", done_cnt); else pass++;
    endtask

    task automatic test_random_stall();
        logic [NB_DATA-1:0] d;
        int lat, fd;
        for (int r = 0; r < 4; r++) begin
            d = rand_data();
            build_expected(d);
            drive_dump(d, 1, 0, 1'b1, 0, 0, '0, lat);
            fd = first_diff(NB_BYTES);
            chk++; if (wr_q.size() != NB_BYTES) $display("FAIL rand%0d_count: got %0d exp %0d", r, wr_q.size(), NB_BYTES); else pass++;
            chk++; if (fd != -1) $display("FAIL rand%0d_bytes: first bad byte index %0d exp none", r, fd); else pass++;
            chk++; if (done_cnt != 1) $display("FAIL rand%0d_done_count: got %0d exp 1", r, done_cnt); else pass++;
        end
    endtask

    task automatic test_restart_ignored();
        logic [NB_DATA-1:0] d, alt;
        int lat, fd;
        d   = rand_data();
        alt = ~d;
        build_expected(d);
        drive_dump(d, 1, 0, 1'b0, 20, 1, alt, lat);
        fd = first_diff(NB_BYTES);
        chk++; if (wr_q.size() != NB_BYTES) $display("FAIL restart_count: got %0d exp %0d", wr_q.size(), NB_BYTES); else pass++;
        chk++; if (fd != -1) $display("FAIL restart_bytes: first bad byte index %0d exp none", fd); else pass++;
        chk++; if (done_cnt != 1) $display("FAIL restart_done_count: got %0d exp 1", done_cnt); else pass++;
        chk++; if (lat != 45) $display("FAIL restart_latency: got %0d exp 45", lat); else pass++;
    endtask

    task automatic test_abort();
        logic [NB_DATA-1:0] d;
        int lat, fd;
        d = rand_data();
        build_expected(d);
        drive_dump(d, 1, 0, 1'b0, 10, 2, '0, lat);
        fd = first_diff(11);
        chk++; if (wr_q.size() != 11) $display("FAIL abort_count: got %0d exp 11", wr_q.size()); else pass++;
        chk++; if (fd != -1) $display("FAIL abort_bytes: first bad byte index %0d exp none", fd); else pass++;
        chk++; if (done_cnt != 0) $display("FAIL abort_done_count: got %0d exp 0", done_cnt); else pass++;
        chk++; if (pa_wr !== 1'b0) $display("FAIL abort_wr: got %b exp 0", pa_wr); else pass++;
        chk++; if (pa_busy !== 1'b0) $display("FAIL abort_busy: got %b exp 0", pa_busy); else pass++;
        d = rand_data();
        build_expected(d);
        drive_dump(d, 1, 0, 1'b0, 0, 0, '0, lat);
        fd = first_diff(NB_BYTES);
        chk++; if (wr_q.size() != NB_BYTES) $display("FAIL abort_redump_count: got %0d exp %0d", wr_q.size(), NB_BYTES); else pass++;
        chk++; if (fd != -1) $display("FAIL abort_redump_bytes: first bad byte index %0d exp none", fd); else pass++;
        chk++; if (lat != 45) $display("FAIL abort_redump_latency: got %0d exp 45", lat); else pass++;
    endtask

    task automatic test_reset_mid();
        logic [NB_DATA-1:0] d;
        int lat, fd;
        d = rand_data();
        build_expected(d);
        drive_dump(d, 1, 0, 1'b0, 30, 3, '0, lat);
        fd = first_diff(31);
        chk++; if (wr_q.size() != 31) $display("FAIL rstmid_count: got %0d exp 31", wr_q.size()); else pass++;
        chk++; if (fd != -1) $display("FAIL rstmid_bytes: first bad byte index %0d exp none", fd); else pass++;
        chk++; if (done_cnt != 0) $display("FAIL rstmid_done_count: got %0d exp 0", done_cnt); else pass++;
        chk++; if (pa_wr !== 1'b0) $display("FAIL rstmid_wr: got %b exp 0", pa_wr); else pass++;
        chk++; if (pa_busy !== 1'b0) $display("FAIL rstmid_busy: got %b exp 0", pa_busy); else pass++;
        chk++; if (pa_data !== 8'h00) $display("FAIL rstmid_data: got %h exp 00", pa_data); else pass++;
        chk++; if (pa_done !== 1'b0) $display("FAIL rstmid_done: got %b exp 0", pa_done); else pass++;
        d = rand_data();
        build_expected(d);
        drive_dump(d, 1, 0, 1'b0, 0, 0, '0, lat);
        fd = first_diff(NB_BYTES);
        chk++; if (wr_q.size() != NB_BYTES) $display("FAIL rstmid_redump_count: got %0d exp %0d", wr_q.size(), NB_BYTES); else pass++;
        chk++; if (fd != -1) $display("FAIL rstmid_redump_bytes: first bad byte index %0d exp none", fd); else pass++;
        chk++; if (lat != 45) $display("FAIL rstmid_redump_latency: got %0d exp 45", lat); else pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        i_start   = 1'b0;
        i_abort   = 1'b0;
        i_tx_full = 1'b0;
        i_data    = '0;
        done_cnt  = 0;
        done_cyc  = 0;
        test_reset();
        test_basic();
        test_all_ones();
        test_stall();
        test_random_stall();
        test_restart_ignored();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule : tb_latch_dump_serializer
